// File: rtl/bus_demux_nline.sv
// Purpose : routes one input word to one of LINES single-entry output channels chosen by sel
//           (optional broadcast to all channels when built with DEMUX_BCAST_EN).
// Latency : 1 clock from accepted input to out_valid/out_data of the target channel.
// Backpressure: in_ready drops when the selected channel (or any channel, on broadcast) is full
//               and not being drained this cycle; an illegal sel is always accepted and dropped.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low clear of all channels and err
//   in_data    word to route, qualified by in_valid
//   in_valid   in_data/sel (and bcast) valid this cycle
//   in_ready   combinational accept for the current sel/bcast
//   sel        destination channel index
//   bcast      (DEMUX_BCAST_EN only) load every channel instead of channel sel
//   out_data   channel k word at [k*WIDTH +: WIDTH]; retains last value while invalid
//   out_valid  channel k holds an undelivered word
//   out_ready  channel k consumer takes its word this cycle
//   err        sticky: a word was dropped because sel >= LINES
//
// Configuration macro: DEMUX_BCAST_EN (adds port bcast and the broadcast path).
module bus_demux_nline #(
  parameter int WIDTH = 8,
  parameter int LINES = 4,
  parameter int SEL_W = $clog2(LINES)
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
`ifdef DEMUX_BCAST_EN
  input  logic                   bcast,
`endif
  output logic [LINES*WIDTH-1:0] out_data,
  output logic [LINES-1:0]       out_valid,
  input  logic [LINES-1:0]       out_ready,
  output logic                   err
);

  // One extra bit so LINES itself is representable next to sel.
  localparam logic [SEL_W:0] LINES_V = (SEL_W+1)'(LINES);

  logic [LINES-1:0] free;      // channel can take a word on this edge
  logic [LINES-1:0] sel_hot;   // one-hot decode of sel; all zero when sel is out of range
  logic             sel_legal;
  logic             free_sel;
  logic             xfer;
  logic [LINES-1:0] load;
  logic             drop;

  // A full channel that is being drained this cycle can be reloaded on the same edge.
  assign free      = ~out_valid | out_ready;
  assign sel_legal = ({1'b0, sel} < LINES_V);

  always_comb begin
    sel_hot = '0;
    for (int k = 0; k < LINES; k++) begin
      if ({1'b0, sel} == (SEL_W+1)'(k)) begin
        sel_hot[k] = 1'b1;
      end
    end
  end

  assign free_sel = |(free & sel_hot);

`ifdef DEMUX_BCAST_EN
  // Broadcast waits for every channel so no channel ever gets a partial copy.
  assign in_ready = bcast ? (&free) : (~sel_legal | free_sel);
  assign xfer     = in_valid & in_ready;
  assign load     = xfer ? (bcast ? {LINES{1'b1}} : sel_hot) : '0;
  assign drop     = xfer & ~bcast & ~sel_legal;
`else
  // Illegal sel is accepted so the producer never deadlocks; the word is discarded.
  assign in_ready = ~sel_legal | free_sel;
  assign xfer     = in_valid & in_ready;
  assign load     = xfer ? sel_hot : '0;
  assign drop     = xfer & ~sel_legal;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_valid <= '0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      for (int k = 0; k < LINES; k++) begin
        if (load[k]) begin
          // Reload wins over delivery: valid stays high and the new word appears.
          out_data[k*WIDTH +: WIDTH] <= in_data;
          out_valid[k]               <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (drop) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_demux_nline.sv
// Purpose : self-checking bench for bus_demux_nline; a 4-line and a 3-line instance run side by side
//           against a channel-occupancy reference model, with directed steps then random traffic.
// Latency : model expects routed words one clock after acceptance.
// Backpressure: model derives in_ready from channel occupancy and the consumer ready inputs.
module tb_bus_demux_nline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_n;
  logic [7:0] t_data  [2];
  logic       t_valid [2];
  logic [1:0] t_sel   [2];
  logic [3:0] t_ordy  [2];
  logic       t_bc;

  logic        a_in_ready, b_in_ready;
  logic [31:0] a_out_data;
  logic [23:0] b_out_data;
  logic [3:0]  a_out_valid;
  logic [2:0]  b_out_valid;
  logic        a_err, b_err;

  int compared   = 0;
  int mismatched = 0;

  int n_lines [2] = '{4, 3};

  // Reference: each channel is a one-word mailbox (full flag + word), plus a sticky drop flag.
  logic       m_full [2][4];
  logic [7:0] m_word [2][4];
  logic       m_err  [2];

  bus_demux_nline #(.WIDTH(8), .LINES(4)) u_a (
    .clk(clk), .clr_n(clr_n),
    .in_data(t_data[0]), .in_valid(t_valid[0]), .in_ready(a_in_ready), .sel(t_sel[0]),
`ifdef DEMUX_BCAST_EN
    .bcast(t_bc),
`endif
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(t_ordy[0]), .err(a_err)
  );

  bus_demux_nline #(.WIDTH(8), .LINES(3)) u_b (
    .clk(clk), .clr_n(clr_n),
    .in_data(t_data[1]), .in_valid(t_valid[1]), .in_ready(b_in_ready), .sel(t_sel[1]),
`ifdef DEMUX_BCAST_EN
    .bcast(t_bc),
`endif
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(t_ordy[1][2:0]), .err(b_err)
  );

  function automatic logic obs_ready(int i);
    return (i == 0) ? a_in_ready : b_in_ready;
  endfunction

  function automatic logic obs_valid(int i, int k);
    return (i == 0) ? a_out_valid[k] : b_out_valid[k];
  endfunction

  function automatic logic [7:0] obs_data(int i, int k);
    return (i == 0) ? a_out_data[k*8 +: 8] : b_out_data[k*8 +: 8];
  endfunction

  function automatic logic obs_err(int i);
    return (i == 0) ? a_err : b_err;
  endfunction

  function automatic logic exp_free(int i, int k);
    return !m_full[i][k] || t_ordy[i][k];
  endfunction

  function automatic logic exp_ready(int i);
    logic all_free = 1'b1;
    for (int k = 0; k < n_lines[i]; k++) all_free &= exp_free(i, k);
    if (t_bc) return all_free;
    if (int'(t_sel[i]) >= n_lines[i]) return 1'b1;
    return exp_free(i, int'(t_sel[i]));
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < n_lines[i]; k++) begin
        check($sformatf("%s dut%0d out_valid[%0d]", tag, i, k), 32'(obs_valid(i, k)), 32'(m_full[i][k]));
        check($sformatf("%s dut%0d out_data[%0d]", tag, i, k), 32'(obs_data(i, k)), 32'(m_word[i][k]));
      end
      check($sformatf("%s dut%0d err", tag, i), 32'(obs_err(i)), 32'(m_err[i]));
    end
  endtask

  task automatic set_in(int i, logic v, logic [1:0] s, logic [7:0] d, logic [3:0] r);
    t_valid[i] = v;
    t_sel[i]   = s;
    t_data[i]  = d;
    t_ordy[i]  = r;
  endtask

  // Called 1 time unit after a rising edge with inputs already applied.
  task automatic step(string tag);
    logic       nf [2][4];
    logic [7:0] nw [2][4];
    logic       ne [2];
    logic       acc;
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s dut%0d in_ready", tag, i), 32'(obs_ready(i)), 32'(exp_ready(i)));
      acc = t_valid[i] && exp_ready(i);
      for (int k = 0; k < 4; k++) begin
        nf[i][k] = m_full[i][k];
        nw[i][k] = m_word[i][k];
        if (k < n_lines[i]) begin
          if (acc && (t_bc || int'(t_sel[i]) == k)) begin
            nf[i][k] = 1'b1;
            nw[i][k] = t_data[i];
          end else if (m_full[i][k] && t_ordy[i][k]) begin
            nf[i][k] = 1'b0;
          end
        end
      end
      ne[i] = m_err[i] || (acc && !t_bc && int'(t_sel[i]) >= n_lines[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_full[i][k] = nf[i][k];
        m_word[i][k] = nw[i][k];
      end
      m_err[i] = ne[i];
    end
    check_outputs(tag);
  endtask

  // Called 1 time unit after a rising edge; pulls clr_n low mid-cycle, holds it over one edge.
  task automatic do_reset(string tag);
    #2;
    clr_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_full[i][k] = 1'b0;
        m_word[i][k] = 8'h00;
      end
      m_err[i] = 1'b0;
    end
    check_outputs({tag, " async"});
    for (int i = 0; i < 2; i++)
      check($sformatf("%s dut%0d in_ready in reset", tag, i), 32'(obs_ready(i)), 32'(exp_ready(i)));
    @(posedge clk);
    #1;
    check_outputs({tag, " held"});
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    t_bc  = 1'b0;
    for (int i = 0; i < 2; i++) set_in(i, 1'b0, 2'd0, 8'h00, 4'h0);
    @(posedge clk);
    #1;
    // Valid words offered during reset must not be taken.
    set_in(0, 1'b1, 2'd1, 8'h5A, 4'h0);
    set_in(1, 1'b1, 2'd2, 8'hC3, 4'h0);
    do_reset("por");
    for (int i = 0; i < 2; i++) set_in(i, 1'b0, 2'd0, 8'h00, 4'h0);

    // Single word to channel 0, then channel 0 blocks.
    set_in(0, 1'b1, 2'd0, 8'h07, 4'h0);
    step("w07");
    check("w07 a_out_valid", 32'(a_out_valid), 32'h1);
    check("w07 ch0", 32'(a_out_data[7:0]), 32'h07);
    set_in(0, 1'b0, 2'd0, 8'h00, 4'h0);
    step("w07 hold");
    check("w07 in_ready sel0", 32'(a_in_ready), 32'h0);

    // Full throughput on channel 1 while draining every cycle.
    set_in(0, 1'b1, 2'd1, 8'h11, 4'h0);
    step("ch1 fill");
    for (int j = 0; j < 4; j++) begin
      set_in(0, 1'b1, 2'd1, 8'hA5 + 8'(j), 4'b0010);
      step($sformatf("ch1 stream%0d", j));
      check($sformatf("ch1 stream%0d valid", j), 32'(a_out_valid[1]), 32'h1);
      check($sformatf("ch1 stream%0d data", j), 32'(a_out_data[15:8]), 32'(8'hA5 + 8'(j)));
    end
    set_in(0, 1'b0, 2'd0, 8'h00, 4'hF);
    step("drain");

    // Channel 2 full and stalled: new word waits.
    set_in(0, 1'b1, 2'd2, 8'h22, 4'h0);
    step("ch2 fill");
    for (int j = 0; j < 3; j++) begin
      set_in(0, 1'b1, 2'd2, 8'h33, 4'h0);
      step($sformatf("ch2 stall%0d", j));
      check($sformatf("ch2 stall%0d data", j), 32'(a_out_data[23:16]), 32'h22);
    end
    set_in(0, 1'b1, 2'd2, 8'h33, 4'b0100);
    step("ch2 release");
    check("ch2 release data", 32'(a_out_data[23:16]), 32'h33);
    set_in(0, 1'b0, 2'd0, 8'h00, 4'hF);
    step("drain2");

    // Illegal sel on the 3-line instance.
    set_in(1, 1'b1, 2'd3, 8'hFF, 4'h0);
    step("bad sel");
    check("bad sel err", 32'(b_err), 32'h1);
    check("bad sel valid", 32'(b_out_valid), 32'h0);
    set_in(1, 1'b0, 2'd0, 8'h00, 4'h0);
    for (int j = 0; j < 3; j++) step($sformatf("err sticky%0d", j));
    check("err sticky", 32'(b_err), 32'h1);

`ifdef DEMUX_BCAST_EN
    set_in(0, 1'b0, 2'd0, 8'h00, 4'hF);
    set_in(1, 1'b0, 2'd0, 8'h00, 4'hF);
    step("bc drain");
    t_bc = 1'b1;
    set_in(0, 1'b1, 2'd1, 8'h3C, 4'h0);
    set_in(1, 1'b1, 2'd3, 8'h3C, 4'h0);
    step("bc load");
    check("bc a_out_valid", 32'(a_out_valid), 32'hF);
    check("bc a_out_data", a_out_data, 32'h3C3C3C3C);
    check("bc b_out_data", 32'(b_out_data), 32'h3C3C3C);
    set_in(0, 1'b1, 2'd2, 8'h55, 4'b1110);
    set_in(1, 1'b1, 2'd0, 8'h55, 4'b0110);
    step("bc blocked");
    t_bc = 1'b0;
`endif

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
`ifdef DEMUX_BCAST_EN
      t_bc = ($urandom_range(0, 7) == 0);
`endif
      for (int i = 0; i < 2; i++)
        set_in(i, ($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
      step($sformatf("rnd%0d", n));
    end
    t_bc = 1'b0;

    // Fill every channel, then clear mid-clock.
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1'b1, 2'(k), 8'h80 + 8'(k), 4'h0);
      set_in(1, 1'b1, 2'(k % 3), 8'h90 + 8'(k), 4'h0);
      step($sformatf("fill%0d", k));
    end
    set_in(1, 1'b1, 2'd3, 8'hEE, 4'h0);
    step("err before clr");
    check("err before clr", 32'(b_err), 32'h1);
    do_reset("mid clr");
    check("mid clr a_out_data", a_out_data, 32'h0);
    check("mid clr b_err", 32'(b_err), 32'h0);

    // First edge after release must accept.
    set_in(0, 1'b1, 2'd3, 8'h4D, 4'h0);
    set_in(1, 1'b1, 2'd2, 8'h6E, 4'h0);
    step("post clr");
    check("post clr ch3", 32'(a_out_data[31:24]), 32'h4D);
    check("post clr b ch2", 32'(b_out_data[23:16]), 32'h6E);

    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 2; i++)
        set_in(i, ($urandom_range(0, 1) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
      step($sformatf("rnd2_%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
